// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Time-multiplexes four BCD clock digits onto a 4-digit common-anode
// seven-segment display. Each digit owns a slot of DIGIT_CYCLES clocks. The
// first GUARD_CYCLES of every slot keep all anodes off, so the segment bus can
// settle before the next digit lights and no ghosting is visible. The colon
// (DP of digit 2) blinks with a synchronised copy of clk1sec.
//
// The four digits and blank_lead are copied into shadow registers once per
// frame, when the scan enters slot 0. All decoding reads the shadow copy, so
// one frame never mixes old and new digits.
//
// Optional feature: define SEG7_DIM_EN to add the bright[2:0] input. The
// lit part of each DRIVE window then shrinks to (bright+1)/8 of the window;
// bright=7 gives full brightness.
//
// Parameters
//   DIGIT_CYCLES  clk100MHz cycles per digit slot (>= 2)
//   GUARD_CYCLES  blank cycles at the start of each slot (< DIGIT_CYCLES)
//
// Ports
//   clk100MHz   in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   d3..d0      in   4  tens-hours, ones-hours, tens-minutes, ones-minutes
//   blank_lead  in   1  1 = suppress d3 when it is zero
//   clk1sec     in   1  1 Hz square wave, asynchronous to clk100MHz
//   bright      in   3  brightness, only with SEG7_DIM_EN
//   an          out  4  digit anodes, active-low, an[i] selects digit di
//   seg         out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp          out  1  decimal point / colon, active-low
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int GUARD_CYCLES = 2000
) (
    input  logic       clk100MHz,
    input  logic       rst_n,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic       blank_lead,
    input  logic       clk1sec,
`ifdef SEG7_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PRE_W = $clog2(DIGIT_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(DIGIT_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_GUARD = PRE_W'(GUARD_CYCLES);

    typedef enum logic {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [3:0] d3;
        logic [3:0] d2;
        logic [3:0] d1;
        logic [3:0] d0;
        logic       blank_lead;
    } shadow_t;

    logic [PRE_W-1:0] pre, pre_nxt;
    logic [1:0]       idx, idx_nxt;
    state_t           state, state_nxt;
    shadow_t          shadow, shadow_nxt;
    logic             sync_ff, colon_on;
    logic             frame_start;
    logic             lead_off;
    logic             dim_on;
    logic [3:0]       digit;
    logic [3:0]       an_nxt;
`ifdef SEG7_DIM_EN
    logic [2:0]       bright_sh, bright_nxt;
    logic [31:0]      dim_pos, dim_lim;
`endif

    // Active-low seven-segment decode; 10..15 show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'b0111111;
        unique case (v)
            4'd0: s = 7'b1000000;
            4'd1: s = 7'b1111001;
            4'd2: s = 7'b0100100;
            4'd3: s = 7'b0110000;
            4'd4: s = 7'b0011001;
            4'd5: s = 7'b0010010;
            4'd6: s = 7'b0000010;
            4'd7: s = 7'b1111000;
            4'd8: s = 7'b0000000;
            4'd9: s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // All registered outputs are computed from the *next* counter values, so
    // an/seg/dp line up with the pre/idx that the counters hold in the same
    // cycle (e.g. seg is already valid on the pre=0 cycle of its slot).
    always_comb begin
        // NOTE: every signal written here is given a default first, so no
        // path leaves it unassigned and no latch is inferred.
        pre_nxt    = pre + PRE_W'(1);
        idx_nxt    = idx;
        shadow_nxt = shadow;
        state_nxt  = state;
        digit      = '0;
        an_nxt     = 4'b1111;
`ifdef SEG7_DIM_EN
        bright_nxt = bright_sh;
        dim_pos    = '0;
        dim_lim    = '0;
`endif

        if (pre == PRE_LAST) begin
            pre_nxt = '0;
            idx_nxt = idx + 2'd1;
        end

        // Entering slot 0 of a new frame: snapshot the inputs.
        frame_start = (pre_nxt == '0) && (idx_nxt == 2'd0);
        if (frame_start) begin
            shadow_nxt = '{d3: d3, d2: d2, d1: d1, d0: d0, blank_lead: blank_lead};
`ifdef SEG7_DIM_EN
            bright_nxt = bright;
`endif
        end

        unique case (state)
            GUARD: if (pre_nxt >= PRE_GUARD) state_nxt = DRIVE;
            DRIVE: if (pre_nxt <  PRE_GUARD) state_nxt = GUARD;
            default: state_nxt = GUARD;
        endcase

        lead_off = shadow_nxt.blank_lead && (shadow_nxt.d3 == 4'd0);

        unique case (idx_nxt)
            2'd0: digit = shadow_nxt.d0;
            2'd1: digit = shadow_nxt.d1;
            2'd2: digit = shadow_nxt.d2;
            2'd3: digit = shadow_nxt.d3;
            default: digit = '0;
        endcase

`ifdef SEG7_DIM_EN
        // Only meaningful in DRIVE, where pre_nxt >= GUARD_CYCLES.
        dim_pos = 32'(pre_nxt - PRE_GUARD) << 3;
        dim_lim = (32'(bright_nxt) + 32'd1) * 32'(DIGIT_CYCLES - GUARD_CYCLES);
        dim_on  = dim_pos < dim_lim;
`else
        dim_on  = 1'b1;
`endif

        if ((state_nxt == DRIVE) && dim_on && !((idx_nxt == 2'd3) && lead_off))
            an_nxt[idx_nxt] = 1'b0;
    end

    always_ff @(posedge clk100MHz or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow digits and both synchroniser flops are reset
            // too, so the first frame after reset decodes known values.
            pre      <= '0;
            idx      <= '0;
            state    <= GUARD;
            shadow   <= '0;
            sync_ff  <= 1'b0;
            colon_on <= 1'b0;
            an       <= 4'b1111;
            seg      <= 7'b1111111;
            dp       <= 1'b1;
`ifdef SEG7_DIM_EN
            bright_sh <= 3'd7;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every register samples the pre-edge values of the others.
            pre      <= pre_nxt;
            idx      <= idx_nxt;
            state    <= state_nxt;
            shadow   <= shadow_nxt;
            sync_ff  <= clk1sec;
            colon_on <= sync_ff;
            an       <= an_nxt;
`ifdef SEG7_DIM_EN
            bright_sh <= bright_nxt;
`endif
            // seg/dp change only at slot start and settle during GUARD.
            if (pre_nxt == '0) begin
                seg <= ((idx_nxt == 2'd3) && lead_off) ? 7'b1111111 : seg_decode(digit);
                dp  <= !((idx_nxt == 2'd2) && colon_on);
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Directed bench for seg7_scan_driver with DIGIT_CYCLES=8, GUARD_CYCLES=2.
// The bench tracks the scan position itself from the number of clocks since
// reset release (k): pre = k%8, idx = (k/8)%4, one frame = 32 clocks.
// A table of digit vectors is applied one per frame and every cycle of the
// following frame is compared; hand-written sequences cover shadow tearing,
// colon synchronisation and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    localparam int DC    = 8;
    localparam int GC    = 2;
    localparam int FRAME = 4 * DC;

    logic       clk100MHz;
    logic       rst_n;
    logic [3:0] d3, d2, d1, d0;
    logic       blank_lead;
    logic       clk1sec;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
`ifdef SEG7_DIM_EN
    logic [2:0] bright;
    logic [3:0] an_dim;
    logic [6:0] seg_dim;
    logic       dp_dim;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int k       = 0;

    typedef struct {
        logic [3:0] d3, d2, d1, d0;
        logic       lb;
        logic       c1s;
        logic [6:0] s3, s2, s1, s0;
    } vec_t;

    vec_t vecs[6];

    seg7_scan_driver #(.DIGIT_CYCLES(DC), .GUARD_CYCLES(GC)) u_dut (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .blank_lead(blank_lead),
        .clk1sec   (clk1sec),
`ifdef SEG7_DIM_EN
        .bright    (bright),
`endif
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

`ifdef SEG7_DIM_EN
    seg7_scan_driver #(.DIGIT_CYCLES(18), .GUARD_CYCLES(2)) u_dim (
        .clk100MHz (clk100MHz),
        .rst_n     (rst_n),
        .d3        (d3),
        .d2        (d2),
        .d1        (d1),
        .d0        (d0),
        .blank_lead(blank_lead),
        .clk1sec   (clk1sec),
        .bright    (bright),
        .an        (an_dim),
        .seg       (seg_dim),
        .dp        (dp_dim)
    );
`endif

    initial clk100MHz = 1'b0;
    always #5 clk100MHz = ~clk100MHz;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, k=%0d", k);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (k=%0d)", name, act, exp, k);
        end
    endtask

    task automatic step();
        @(posedge clk100MHz);
        #1;
        k++;
    endtask

    task automatic goto_pos(input int pos);
        while (k % FRAME != pos) step();
    endtask

    task automatic to_frame();
        step();
        while (k % FRAME != 0) step();
    endtask

    task automatic apply(input vec_t v);
        d3 = v.d3; d2 = v.d2; d1 = v.d1; d0 = v.d0;
        blank_lead = v.lb;
        clk1sec    = v.c1s;
    endtask

    // Expected anodes for the current scan position.
    function automatic logic [3:0] exp_an(input int kk, input logic lead_off);
        int pre, idx;
        pre = kk % DC;
        idx = (kk / DC) % 4;
        if (pre < GC) return 4'b1111;
        if (idx == 3 && lead_off) return 4'b1111;
        return ~(4'b0001 << idx);
    endfunction

    // Compare every cycle of one frame; must be called at k%FRAME == 0.
    task automatic check_frame(input int vi, input vec_t v);
        logic       lead_off;
        logic [6:0] es;
        int         idx;
        lead_off = v.lb && (v.d3 == 4'd0);
        for (int c = 0; c < FRAME; c++) begin
            idx = (k / DC) % 4;
            case (idx)
                0:       es = v.s0;
                1:       es = v.s1;
                2:       es = v.s2;
                default: es = v.s3;
            endcase
            check($sformatf("vec%0d an c%0d", vi, c), {3'b0, an}, {3'b0, exp_an(k, lead_off)});
            check($sformatf("vec%0d seg c%0d", vi, c), seg, es);
            check($sformatf("vec%0d dp c%0d", vi, c), {6'b0, dp},
                  {6'b0, !((idx == 2) && v.c1s)});
            step();
        end
    endtask

    initial begin
        //           d3     d2     d1      d0     lb    c1s   s3          s2          s1          s0
        vecs[0] = '{4'd1,  4'd2,  4'd0,  4'd0,  1'b0, 1'b0, 7'b1111001, 7'b0100100, 7'b1000000, 7'b1000000};
        vecs[1] = '{4'd0,  4'd9,  4'd1,  4'd3,  1'b1, 1'b1, 7'b1111111, 7'b0010000, 7'b1111001, 7'b0110000};
        vecs[2] = '{4'd0,  4'd9,  4'd1,  4'd3,  1'b0, 1'b1, 7'b1000000, 7'b0010000, 7'b1111001, 7'b0110000};
        vecs[3] = '{4'd8,  4'd7,  4'd12, 4'd5,  1'b1, 1'b0, 7'b0000000, 7'b1111000, 7'b0111111, 7'b0010010};
        vecs[4] = '{4'd15, 4'd6,  4'd10, 4'd4,  1'b0, 1'b1, 7'b0111111, 7'b0000010, 7'b0111111, 7'b0011001};
        vecs[5] = '{4'd0,  4'd0,  4'd8,  4'd6,  1'b1, 1'b0, 7'b1111111, 7'b1000000, 7'b0000000, 7'b0000010};

        rst_n = 1'b0;
        d3 = '0; d2 = '0; d1 = '0; d0 = '0;
        blank_lead = 1'b0;
        clk1sec    = 1'b0;
`ifdef SEG7_DIM_EN
        bright = 3'd3;
`endif

        // ---- reset state and first DRIVE cycle -------------------------------
        repeat (3) @(posedge clk100MHz);
        #1;
        check("reset an",  {3'b0, an}, 7'b0001111);
        check("reset seg", seg,        7'b1111111);
        check("reset dp",  {6'b0, dp}, 7'b0000001);
        rst_n = 1'b1;
        k = 0;
        check("rel pre0 an", {3'b0, an}, 7'b0001111);
        step();
        check("rel pre1 an", {3'b0, an}, 7'b0001111);
        step();
        check("rel pre2 an", {3'b0, an}, 7'b0001110);
        step();
        check("rel pre3 an", {3'b0, an}, 7'b0001110);

        // ---- table-driven frames --------------------------------------------
        for (int i = 0; i < 6; i++) begin
            apply(vecs[i]);
            to_frame();
            check_frame(i, vecs[i]);
        end

        // ---- shadow latch: change inputs mid-frame ---------------------------
        d3 = 4'd1; d2 = 4'd2; d1 = 4'd0; d0 = 4'd3;
        blank_lead = 1'b0;
        clk1sec    = 1'b0;
        to_frame();
        check("tear idx0 old d0", seg, 7'b0110000);
        goto_pos(2 * DC + 3);
        d3 = 4'd5; d0 = 4'd4;
        goto_pos(3 * DC + 1);
        check("tear idx3 old d3", seg, 7'b1111001);
        goto_pos(3 * DC + GC);
        check("tear idx3 an", {3'b0, an}, 7'b0000111);
        to_frame();
        check("tear idx0 new d0", seg, 7'b0011001);
        goto_pos(3 * DC);
        check("tear idx3 new d3", seg, 7'b0010010);

        // ---- colon synchroniser ----------------------------------------------
        to_frame();
        goto_pos(2 * DC - 1);
        clk1sec = 1'b1;
        step();
        check("colon late slot0", {6'b0, dp}, 7'b0000001);
        goto_pos(2 * DC + 5);
        check("colon late slot5", {6'b0, dp}, 7'b0000001);
        to_frame();
        check("colon idx0 dp", {6'b0, dp}, 7'b0000001);
        goto_pos(2 * DC);
        check("colon on idx2", {6'b0, dp}, 7'b0000000);
        goto_pos(2 * DC + DC - 1);
        check("colon on idx2 end", {6'b0, dp}, 7'b0000000);
        goto_pos(3 * DC);
        check("colon idx3 dp", {6'b0, dp}, 7'b0000001);
        clk1sec = 1'b0;
        to_frame();
        goto_pos(2 * DC + 1);
        check("colon off idx2", {6'b0, dp}, 7'b0000001);

        // ---- asynchronous reset mid-DRIVE of idx2 ----------------------------
        goto_pos(2 * DC + 4);
        check("pre-rst an", {3'b0, an}, 7'b0001011);
        rst_n = 1'b0;
        #1;
        check("async rst an",  {3'b0, an}, 7'b0001111);
        check("async rst seg", seg,        7'b1111111);
        check("async rst dp",  {6'b0, dp}, 7'b0000001);
        @(posedge clk100MHz);
        #1;
        rst_n = 1'b1;
        k = 0;
        check("restart pre0 an", {3'b0, an}, 7'b0001111);
        step();
        check("restart pre1 an", {3'b0, an}, 7'b0001111);
        step();
        check("restart pre2 an", {3'b0, an}, 7'b0001110);
        goto_pos(DC + GC);
        check("restart idx1 an", {3'b0, an}, 7'b0001101);

`ifdef SEG7_DIM_EN
        // ---- dimming: 18-cycle slots, 2 guard, bright=3 ----------------------
        begin
            int lit;
            lit = 0;
            while (k < 72 || (k % 72) != 0) step();
            for (int c = 0; c < 18; c++) begin
                if (an_dim == 4'b1110) lit++;
                step();
            end
            check("dim lit cycles", 7'(lit), 7'd8);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Downstream consumer of the clock-digit outputs (tenhrout, onehrout, tenminout, oneminout).
- Time-multiplexes four BCD digits onto a 4-digit common-anode seven-segment display, one digit at a time.
- Inserts a dead-time guard band between digits to prevent ghosting.
- Drives the hour/minute colon as a DP blinking with clk1sec.

Parameters:
DIGIT_CYCLES, 100000, clk100MHz cycles per digit slot (1 kHz per digit); must be >= 2
GUARD_CYCLES, 2000, blank cycles at start of each slot; 0 <= GUARD_CYCLES < DIGIT_CYCLES

Ports:
clk100MHz  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
d3  in  4  tens-of-hours digit (from tenhrout)
d2  in  4  ones-of-hours digit (from onehrout)
d1  in  4  tens-of-minutes digit (from tenminout)
d0  in  4  ones-of-minutes digit (from oneminout)
blank_lead  in  1  1 = suppress d3 when it is 0
clk1sec  in  1  1 Hz square wave, asynchronous to clk100MHz
an  out  4  digit anodes, active-low, an[i] selects digit di
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point / colon, active-low

Behaviour:
- Reset (rst_n=0, takes effect immediately):
  - an=4'b1111, seg=7'b1111111, dp=1.
  - pre=0, idx=0, state=GUARD, shadow digits=0, colon sync flops=0.
- Counters:
  - pre counts 0..DIGIT_CYCLES-1 and wraps.
  - On wrap, idx advances 0->1->2->3->0 (2-bit natural wrap).
- State machine:
  - GUARD while pre < GUARD_CYCLES: an=1111.
  - DRIVE while pre >= GUARD_CYCLES: an[idx]=0, all other anodes 1.
  - With GUARD_CYCLES=0, state is always DRIVE.
- Shadow latch:
  - On the cycle where pre=0 and idx=0, capture d3..d0 and blank_lead into shadow registers.
  - All decode uses shadow values only, so a frame never tears.
  - An input change appears no later than the start of the next frame (<= 4*DIGIT_CYCLES+1 cycles).
- seg and dp are registered. They change only on the first cycle of a slot (pre=0) and hold for the whole slot, so segments settle during GUARD.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Values 10-15 show dash 0111111.
- Leading blank: if shadow blank_lead=1 and shadow d3=0, an[3] stays 1 for the entire idx=3 slot and seg=1111111.
- Colon:
  - clk1sec passes through a 2-flop synchronizer to give colon_on.
  - dp=0 only when idx=2 and colon_on=1 (sampled at slot start); otherwise dp=1.
- Reset mid-operation: outputs blank asynchronously. On release, the scan restarts at idx=0 in GUARD.

Optional Feature:
- Macro: SEG7_DIM_EN.
- Defined:
  - Adds input port bright [2:0].
  - Within DRIVE, the anode is enabled only while (pre-GUARD_CYCLES)*8 < (bright+1)*(DIGIT_CYCLES-GUARD_CYCLES); otherwise an=1111.
  - bright is sampled into the shadow registers with the digits.
  - bright=7 gives full brightness.
- Undefined: no bright port; the anode is enabled for the whole DRIVE window.

Test Plan (DIGIT_CYCLES=8, GUARD_CYCLES=2 unless noted):
1. rst_n=0 -> an=1111, seg=1111111, dp=1; release -> first DRIVE cycle is pre=2, an=1110.
2. d3..d0=1,2,0,0, blank_lead=0 -> slot idx0 seg=1000000, idx2 seg=0100100, idx3 seg=1111001; every slot shows an=1111 for 2 cycles, then its single anode low for 6 cycles.
3. d3=0, d2=9, blank_lead=1 -> an[3] is 1 for the whole idx3 slot; blank_lead=0 next frame -> idx3 seg=1000000, an=0111.
4. Change d0 from 3 to 4 during the idx2 slot -> idx0 still shows 0110000 until the next frame, then shows 0011001.
5. clk1sec=1 held -> dp=0 only in idx2 slots, from the slot starting >= 2 cycles later; clk1sec=0 -> dp=1 in all slots; d1=12 -> idx1 seg=0111111.
6. Assert rst_n mid-DRIVE of idx2 -> an=1111 in the same cycle, without waiting for a clock edge; release -> idx0 scan restarts. With SEG7_DIM_EN, DIGIT_CYCLES=18, GUARD_CYCLES=2 and bright=3 -> anode low for 8 of the 16 DRIVE cycles.
